// File: rtl/type3_window.sv
// Sliding-window builder feeding type3: turns a serial pixel stream into
// IMG_NB-wide, row-aligned windows with a configurable horizontal stride.
module type3_window #(
  parameter int unsigned IMG_WIDTH = 16,
  parameter int unsigned IMG_NB    = 3,
  parameter int unsigned ROW_LEN   = 8,
  parameter int unsigned STRIDE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IMG_WIDTH-1:0]          pix,
  input  logic                          pix_val,
  output logic [IMG_WIDTH*IMG_NB-1:0]   img,
  output logic                          val,
  output logic                          row_last
);

  localparam int unsigned COL_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned PH_W     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned HIST_N   = IMG_NB - 1;
  localparam int unsigned WIN_W    = IMG_WIDTH * IMG_NB;
  localparam int unsigned FIRST_COL = IMG_NB - 1;
  localparam int unsigned LAST_COL = FIRST_COL + ((ROW_LEN - IMG_NB) / STRIDE) * STRIDE;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } stage_e;

  // Pixel history (index 0 = oldest), column and stride phase counters
  logic [IMG_WIDTH-1:0] hist_q [HIST_N];
  logic [IMG_WIDTH-1:0] hist_d [HIST_N];
  logic [COL_W-1:0]     col_q, col_d;
  logic [PH_W-1:0]      phase_q, phase_d;

  logic [WIN_W-1:0]     img_q, img_d;
  logic                 val_q, val_d;
  logic                 row_last_q, row_last_d;

  stage_e               stage_c;
  logic [PH_W-1:0]      phase_cur_c;
  logic                 emit_c;
  logic [WIN_W-1:0]     win_c;

  // FILL until the window can first be full within this row
  always_comb begin
    stage_c = (col_q >= COL_W'(FIRST_COL)) ? EMIT : FILL;
  end

  // Phase restarts at the first full window so stride counts from there
  always_comb begin
    phase_cur_c = phase_q;
    emit_c      = 1'b0;
    unique case (stage_c)
      FILL: begin
        phase_cur_c = '0;
        emit_c      = 1'b0;
      end
      EMIT: begin
        if (col_q == COL_W'(FIRST_COL)) begin
          phase_cur_c = '0;
        end
        emit_c = (phase_cur_c == '0);
      end
      default: begin
        phase_cur_c = '0;
        emit_c      = 1'b0;
      end
    endcase
  end

  // Candidate window: history followed by the incoming pixel as newest slice
  always_comb begin
    win_c = '0;
    for (int k = 0; k < int'(HIST_N); k++) begin
      win_c[k*IMG_WIDTH +: IMG_WIDTH] = hist_q[k];
    end
    win_c[HIST_N*IMG_WIDTH +: IMG_WIDTH] = pix;
  end

  // Next-state for counters, history and registered outputs
  always_comb begin
    for (int k = 0; k < int'(HIST_N); k++) begin
      hist_d[k] = hist_q[k];
    end
    col_d      = col_q;
    phase_d    = phase_q;
    img_d      = img_q;
    val_d      = 1'b0;
    row_last_d = 1'b0;

    if (pix_val) begin
      for (int k = 0; k + 1 < int'(HIST_N); k++) begin
        hist_d[k] = hist_q[k+1];
      end
      hist_d[HIST_N-1] = pix;

      col_d = (col_q == COL_W'(ROW_LEN - 1)) ? '0 : col_q + COL_W'(1);

      if (stage_c == EMIT) begin
        phase_d = (phase_cur_c == PH_W'(STRIDE - 1)) ? '0 : phase_cur_c + PH_W'(1);
      end else begin
        phase_d = '0;
      end

      if (emit_c) begin
        img_d      = win_c;
        val_d      = 1'b1;
        row_last_d = (col_q == COL_W'(LAST_COL));
      end
    end
  end

  // State registers; reset wins over an accepted pixel on the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(HIST_N); k++) begin
        hist_q[k] <= '0;
      end
      col_q      <= '0;
      phase_q    <= '0;
      img_q      <= '0;
      val_q      <= 1'b0;
      row_last_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(HIST_N); k++) begin
        hist_q[k] <= hist_d[k];
      end
      col_q      <= col_d;
      phase_q    <= phase_d;
      img_q      <= img_d;
      val_q      <= val_d;
      row_last_q <= row_last_d;
    end
  end

  assign img      = img_q;
  assign val      = val_q;
  assign row_last = row_last_q;

endmodule
